// File: rtl/fft_addr_seq.sv
// fft_addr_seq -- address sequencer for a complete in-place radix-2 FFT.
//
// One start pulse walks all LOG2_N levels. Each level issues N/2 butterfly
// reads, then drains for BFLY_LATENCY cycles, so the final write of a level
// lands before the first read of the next one.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   start_i, inverse_i    start a full FFT; inverse sampled with start
//   stall_i               bubble: hold issue for this cycle
//   busy_o, done_o        busy while issuing/draining; one-cycle done pulse
//   level_o               current level 0..LOG2_N-1
//   rd_en_o, raddra_o, raddrb_o, twiddle_addr_o, twiddle_conj_o
//                         read side (addresses zero outside ISSUE)
//   we_o, waddra_o, waddrb_o
//                         read side delayed by exactly BFLY_LATENCY cycles
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_ISSUE | issuing butterflies of the current level (stall makes bubbles)
// ST_DRAIN | waiting BFLY_LATENCY cycles for the level's writes to land
// ST_DONE  | single-cycle done pulse, then back to idle
module fft_addr_seq #(
    parameter int LOG2_N       = 12,
    parameter int BFLY_LATENCY = 7,
    parameter int LVL_W        = $clog2(LOG2_N)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              inverse_i,
    input  logic              stall_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              rd_en_o,
    output logic [LOG2_N-1:0] raddra_o,
    output logic [LOG2_N-1:0] raddrb_o,
    output logic [LOG2_N-2:0] twiddle_addr_o,
    output logic              twiddle_conj_o,
    output logic              we_o,
    output logic [LOG2_N-1:0] waddra_o,
    output logic [LOG2_N-1:0] waddrb_o
);

    localparam int DCNT_W = (BFLY_LATENCY > 1) ? $clog2(BFLY_LATENCY) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [LOG2_N-2:0] BFLY_LAST = '1;
    localparam logic [LOG2_N-2:0] TW_ONES   = '1;
    localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(LOG2_N - 1);
    localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(BFLY_LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [LOG2_N-2:0] bfly_q, bfly_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              conj_q, conj_d;

    logic              we_pipe_q [BFLY_LATENCY];
    logic [LOG2_N-1:0] wa_pipe_q [BFLY_LATENCY];
    logic [LOG2_N-1:0] wb_pipe_q [BFLY_LATENCY];

    logic issuing;

    // Rotate left within LOG2_N bits: the upper half of {v,v} << s.
    function automatic logic [LOG2_N-1:0] rotl(input logic [LOG2_N-1:0] v,
                                               input logic [LVL_W-1:0]  s);
        logic [2*LOG2_N-1:0] dbl;
        dbl = {v, v} << s;
        return dbl[2*LOG2_N-1:LOG2_N];
    endfunction

    always_comb begin
        state_d = state_q;
        bfly_d  = bfly_q;
        level_d = level_q;
        dcnt_d  = dcnt_q;
        conj_d  = conj_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ISSUE;
                    bfly_d  = '0;
                    level_d = '0;
                    conj_d  = inverse_i;
                end
            end
            ST_ISSUE: begin
                if (!stall_i) begin
                    // Wraps to 0 on the last butterfly, ready for the next level.
                    bfly_d = bfly_q + 1'b1;
                    if (bfly_q == BFLY_LAST) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = DCNT_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == '0) begin
                    if (level_q == LVL_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        level_d = level_q + 1'b1;
                        bfly_d  = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            bfly_q  <= '0;
            level_q <= '0;
            dcnt_q  <= '0;
            conj_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bfly_q  <= bfly_d;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            conj_q  <= conj_d;
        end
    end

    // Addresses are forced to zero outside ISSUE so that idle/reset outputs
    // are all zero; inside ISSUE they stay put across stall bubbles.
    assign issuing        = (state_q == ST_ISSUE);
    assign rd_en_o        = issuing && !stall_i;
    assign raddra_o       = issuing ? rotl({bfly_q, 1'b0}, level_q) : '0;
    assign raddrb_o       = issuing ? rotl({bfly_q, 1'b1}, level_q) : '0;
    // Keep only the top 'level' bits of the butterfly index.
    assign twiddle_addr_o = issuing ? (bfly_q & ~(TW_ONES >> level_q)) : '0;
    assign twiddle_conj_o = conj_q;
    assign busy_o         = issuing || (state_q == ST_DRAIN);
    assign done_o         = (state_q == ST_DONE);
    assign level_o        = level_q;

    // Free-running delay line; stall bubbles simply travel through as we=0.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                we_pipe_q[i] <= 1'b0;
                wa_pipe_q[i] <= '0;
                wb_pipe_q[i] <= '0;
            end
        end else begin
            we_pipe_q[0] <= rd_en_o;
            wa_pipe_q[0] <= raddra_o;
            wb_pipe_q[0] <= raddrb_o;
            for (int i = 1; i < BFLY_LATENCY; i++) begin
                we_pipe_q[i] <= we_pipe_q[i-1];
                wa_pipe_q[i] <= wa_pipe_q[i-1];
                wb_pipe_q[i] <= wb_pipe_q[i-1];
            end
        end
    end

    assign we_o     = we_pipe_q[BFLY_LATENCY-1];
    assign waddra_o = wa_pipe_q[BFLY_LATENCY-1];
    assign waddrb_o = wb_pipe_q[BFLY_LATENCY-1];

endmodule

// File: doc/fft_addr_seq.md
Name:
fft_addr_seq

Overview:
- Parametrised successor to the single-level FFT address generator.
- Sequences a complete in-place radix-2 FFT over all LOG2_N levels from one start pulse.
- Generates dual-port read addresses, write addresses delayed by the butterfly latency, and twiddle addresses, with an inverse flag for twiddle conjugation.
- Adds issue stall and a per-level drain gap, so the next level never reads a word before the previous level has written it.

Parameters:
LOG2_N, 12, log2 of FFT size N; address width (minimum 2).
BFLY_LATENCY, 7, cycles from read issue to write of the same butterfly (minimum 1).
LVL_W, $clog2(LOG2_N), width of the level output (derived; not overridden).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a full FFT; ignored while busy
inverse  input  1  sampled with start; selects IFFT twiddles
stall  input  1  holds issue for the current cycle (a bubble)
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after the final write of the last level
level  output  LVL_W  current level, 0..LOG2_N-1
rd_en  output  1  read addresses valid this cycle
raddra  output  LOG2_N  even-leg read address
raddrb  output  LOG2_N  odd-leg read address
twiddle_addr  output  LOG2_N-1  twiddle ROM address, valid with rd_en
twiddle_conj  output  1  latched inverse; conjugate the twiddle
we  output  1  write strobe for both ports
waddra  output  LOG2_N  raddra delayed by BFLY_LATENCY
waddrb  output  LOG2_N  raddrb delayed by BFLY_LATENCY

Behaviour:
- Reset (asynchronous):
  - State is IDLE; bfly_count, level, drain counter and twiddle_conj are cleared.
  - The rd_en/we delay pipelines are cleared.
  - All outputs are 0.
  - Reset mid-FFT aborts immediately. No done is produced and no we is asserted after reset.
- State IDLE:
  - start=1 moves to ISSUE with level=0 and bfly_count=0.
  - twiddle_conj is latched from inverse.
- State ISSUE:
  - rd_en = !stall.
  - bfly_count (LOG2_N-1 bits) increments only when !stall.
  - On a non-stalled cycle with bfly_count=N/2-1, move to DRAIN with drain counter=0.
- State DRAIN:
  - rd_en=0.
  - The counter counts BFLY_LATENCY cycles.
  - On the last of these cycles:
    - if level<LOG2_N-1: level increments, bfly_count=0, next state is ISSUE;
    - otherwise: next state is DONE.
- State DONE:
  - Lasts one cycle with done=1 and busy=0, then returns to IDLE.
- busy = (state is ISSUE or DRAIN).
- Address generation (combinational from bfly_count and level):
  - raddra = rotl({bfly_count,0}, level) within LOG2_N bits.
  - raddrb = rotl({bfly_count,1}, level) within LOG2_N bits.
  - These are held stable while stalled.
  - rd_en=0 marks the addresses as don't-care.
- Twiddle address:
  - twiddle_addr = bfly_count with its low (LOG2_N-1-level) bits forced to 0.
  - Level 0 therefore always gives 0; the last level gives bfly_count.
- Write side:
  - we, waddra and waddrb equal rd_en, raddra and raddrb registered through exactly BFLY_LATENCY stages.
  - The pipeline always advances; stall never freezes it.
  - Stall bubbles appear as we=0 gaps, BFLY_LATENCY cycles later.
- Hazard rule:
  - The last write of a level occurs in the final DRAIN cycle.
  - The first read of the next level occurs in the following cycle, so read-after-write is guaranteed.
- Latency (no stall): LOG2_N*(N/2+BFLY_LATENCY) cycles from the first ISSUE cycle to the last write; done comes one cycle later.
- Boundary conditions:
  - start while busy or while done: ignored.
  - stall in DRAIN: ignored.
  - stall asserted forever: the block holds in ISSUE, and busy stays 1.

Test Plan:
1. LOG2_N=3, LAT=2, start at cycle 0, no stall:
   - rd_en in cycles 1-4, 7-10 and 13-16;
   - we in cycles 3-6, 9-12 and 15-18;
   - done=1 at cycle 19 with busy=0; busy=1 in cycles 1-18.
2. Same run, checking addresses and twiddles per level:
   - level0: raddra 0,2,4,6; raddrb 1,3,5,7; twiddle 0,0,0,0.
   - level1: raddra 0,4,1,5; raddrb 2,6,3,7; twiddle 0,0,2,2.
   - level2: raddra 0,1,2,3; raddrb 4,5,6,7; twiddle 0,1,2,3.
   - Check waddra/waddrb equal the same sequences, delayed 2 cycles.
3. Stall=1 in cycles 2-3 of test 1:
   - bfly 1 is held; rd_en=0 in cycles 2-3;
   - we=0 in cycles 4-5;
   - level0 completes issue at cycle 6;
   - done is pushed 2 cycles later, to cycle 21.
4. start with inverse=1, then inverse toggled mid-run:
   - twiddle_conj=1 throughout; a second start while busy is ignored.
5. Reset asserted asynchronously at cycle 9 (mid-level1):
   - all outputs are 0 immediately;
   - no we and no done follow;
   - a new start runs a clean, complete sequence.
6. Default LOG2_N=12, LAT=7, check:
   - 12 levels;
   - total 12*(2048+7) cycles from the first issue to the last write;
   - at the last level, twiddle_addr equals bfly_count.
